// File: rtl/mips_pkg.sv
// Shared types and constants for the HI/LO multiply/divide engine.
//   muldiv_op_t    : decoded E-stage HI/LO operation (MULT, MULTU, DIV, DIVU)
//   muldiv_state_t : engine FSM states (IDLE -> RUN -> FIX -> IDLE)
//   MD_WIDTH       : default operand width
//   MD_CNT_W       : iteration counter width for MD_WIDTH
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// E-stage interface between decode/hazard logic and the HI/LO muldiv engine.
//   startE, opE, srcaE, srcbE : launch an operation with forwarded operands
//   mthiE, mtloE              : move srcaE into HI / LO
//   busyE                     : engine in flight (stall request)
//   doneE                     : one-cycle pulse when HI/LO first show a result
//   hi, lo                    : architectural HI/LO
// master = pipeline side, slave = engine side.
interface hilo_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             mthiE;
    logic             mtloE;
    logic             busyE;
    logic             doneE;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, opE, srcaE, srcbE, mthiE, mtloE,
        input  busyE, doneE, hi, lo
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, mthiE, mtloE,
        output busyE, doneE, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the HI/LO engine, purely combinational.
//   i_is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   i_acc     : partial product high half / partial remainder
//   i_shreg   : multiplier bits (LSB first) / dividend bits becoming quotient
//   i_operand : multiplicand / divisor magnitude
//   o_acc, o_shreg : updated acc/shreg for the next iteration
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shreg
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift {carry, acc, shreg} right by one.
        w_sum = {1'b0, i_acc};
        if (i_shreg[0]) begin
            w_sum = {1'b0, i_acc} + {1'b0, i_operand};
        end

        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // The remainder stays below the divisor, so the difference fits WIDTH bits.
        w_trial = {i_acc, i_shreg[WIDTH-1]};
        w_ge    = (w_trial >= {1'b0, i_operand});
        w_diff  = w_trial[WIDTH-1:0] - i_operand;

        if (i_is_div) begin
            o_acc   = w_ge ? w_diff : w_trial[WIDTH-1:0];
            o_shreg = {i_shreg[WIDTH-2:0], w_ge};
        end else begin
            o_acc   = w_sum[WIDTH:1];
            o_shreg = {w_sum[0], i_shreg[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Operates on magnitudes for WIDTH iterations, then applies sign correction
// in a single FIX cycle that writes HI/LO.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : slave side of hilo_muldiv_unit_if (start/op/operands/MT*,
//           busyE/doneE/hi/lo)
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input logic               clk,
    input logic               reset,
    hilo_muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_nxt;
    muldiv_op_t         r_op;
    muldiv_op_t         w_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dvz;
    logic               r_done;

    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_r_is_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_shreg;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand decode and magnitude extraction at launch.
    always_comb begin
        w_op     = muldiv_op_t'(bus.opE);
        w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
        w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
        w_a_neg  = w_signed & bus.srcaE[WIDTH-1];
        w_b_neg  = w_signed & bus.srcbE[WIDTH-1];
        w_a_mag  = w_a_neg ? -bus.srcaE : bus.srcaE;
        w_b_mag  = w_b_neg ? -bus.srcbE : bus.srcbE;
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        w_r_is_div = (r_op == MD_DIV) || (r_op == MD_DIVU);
        w_prod     = {r_acc, r_shreg};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
        w_quo_fix  = r_neg_q ? -r_shreg : r_shreg;
        // Divide by zero leaves the dividend magnitude in acc, so the
        // re-signed remainder equals the dividend; only LO needs forcing.
        if (r_dvz) begin
            w_quo_fix = '1;
        end
        w_rem_fix  = r_neg_r ? -r_acc : r_acc;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div  (w_r_is_div),
        .i_acc     (r_acc),
        .i_shreg   (r_shreg),
        .i_operand (r_operand),
        .o_acc     (w_step_acc),
        .o_shreg   (w_step_shreg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (bus.startE) w_state_nxt = MD_RUN;
            MD_RUN:  if (r_cnt == '0) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= MD_MULT;
            r_acc     <= '0;
            r_shreg   <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dvz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (bus.startE) begin
                        r_op      <= w_op;
                        r_acc     <= '0;
                        r_shreg   <= w_is_div ? w_a_mag : w_b_mag;
                        r_operand <= w_is_div ? w_b_mag : w_a_mag;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_is_div & w_a_neg;
                        r_dvz     <= w_is_div & (bus.srcbE == '0);
                    end else begin
                        if (bus.mthiE) r_hi <= bus.srcaE;
                        if (bus.mtloE) r_lo <= bus.srcaE;
                    end
                end
                MD_RUN: begin
                    r_acc   <= w_step_acc;
                    r_shreg <= w_step_shreg;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                MD_FIX: begin
                    if (w_r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == MD_FIX);
        end
    end

    assign bus.busyE = (r_state != MD_IDLE);
    assign bus.doneE = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

    // The hazard unit must hold off new HI/LO traffic while busy; such
    // requests are dropped here.
    a_no_issue_while_busy: assert property (
        @(posedge clk) disable iff (reset)
        (r_state != MD_IDLE) |-> !(bus.startE || bus.mthiE || bus.mtloE)
    ) else $warning("HI/LO request issued while engine busy; dropped");

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO,
// a monitor pops and compares on every doneE pulse.
module tb_hilo_muldiv_unit;

    typedef struct {
        int          tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   tag_n;
    exp_t sb_q[$];

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.doneE === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got doneE=1 expected no result pending");
            end else begin
                e = sb_q.pop_front();
                check($sformatf("res%0d_hi", e.tag), bus.hi, e.hi);
                check($sformatf("res%0d_lo", e.tag), bus.lo, e.lo);
            end
        end
    end

    // Launch at the next edge (T0); returns at T0+#1 with inputs released.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mthi, input logic push,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_t e;
        @(negedge clk);
        bus.startE = 1'b1;
        bus.opE    = op;
        bus.srcaE  = a;
        bus.srcbE  = b;
        bus.mthiE  = mthi;
        if (push) begin
            e.tag = tag_n;
            e.hi  = exp_hi;
            e.lo  = exp_lo;
            sb_q.push_back(e);
            tag_n++;
        end
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        bus.mthiE  = 1'b0;
        bus.srcaE  = '0;
        bus.srcbE  = '0;
    endtask

    // Called in cycle T0+1; counts cycles until doneE, bounded.
    task automatic wait_result(input logic check_lat);
        int n;
        int busy_n;
        logic seen;
        n = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            n++;
            if (bus.doneE === 1'b1) seen = 1'b1;
            else begin
                if (bus.busyE === 1'b1) busy_n++;
                @(posedge clk);
                #1;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (check_lat) begin
            check("done_cycle", n, 34);
            check("busy_cycles", busy_n, 33);
            check("busy_low_at_done", 32'(bus.busyE), 32'd0);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b, 1'b0, 1'b1, exp_hi, exp_lo);
        wait_result(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        tag_n = 0;
        reset = 1'b1;
        bus.startE = 1'b0;
        bus.opE    = 2'b00;
        bus.srcaE  = '0;
        bus.srcbE  = '0;
        bus.mthiE  = 1'b0;
        bus.mtloE  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busyE), 32'd0);
        check("rst_done", 32'(bus.doneE), 32'd0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // MTHI then MTLO.
        @(negedge clk);
        bus.mthiE = 1'b1; bus.srcaE = 32'h1234;
        @(negedge clk);
        bus.mthiE = 1'b0; bus.mtloE = 1'b1; bus.srcaE = 32'hABCD;
        @(negedge clk);
        bus.mtloE = 1'b0; bus.srcaE = '0;
        check("mthi", bus.hi, 32'h1234);
        check("mtlo", bus.lo, 32'hABCD);
        check("mt_no_busy", 32'(bus.busyE), 32'd0);

        // MTHI and MTLO together.
        bus.mthiE = 1'b1; bus.mtloE = 1'b1; bus.srcaE = 32'h5555;
        @(negedge clk);
        bus.mthiE = 1'b0; bus.mtloE = 1'b0; bus.srcaE = '0;
        check("mtboth_hi", bus.hi, 32'h5555);
        check("mtboth_lo", bus.lo, 32'h5555);

        // startE with MTHI: start wins, HI holds until the result lands.
        issue(2'b01, 32'd3, 32'd4, 1'b1, 1'b1, 32'h0, 32'hC);
        check("start_wins_hi_hold", bus.hi, 32'h5555);
        check("start_busy", 32'(bus.busyE), 32'd1);
        wait_result(1'b1);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        run_op(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op(2'b01, 32'h12345678, 32'h10,       32'h1,        32'h23456780);
        run_op(2'b10, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF);

        // Illegal start/MTHI mid-RUN must be dropped.
        issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.startE = 1'b1; bus.opE = 2'b00; bus.mthiE = 1'b1;
        bus.srcaE = 32'h1; bus.srcbE = 32'h1;
        @(posedge clk);
        #1;
        bus.startE = 1'b0; bus.mthiE = 1'b0; bus.srcaE = '0; bus.srcbE = '0;
        check("midrun_hi_hold", bus.hi, 32'hFFFFFFF7);
        check("midrun_busy", 32'(bus.busyE), 32'd1);
        wait_result(1'b0);

        // Reset during cycle 10 of a DIV aborts immediately.
        issue(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busyE), 32'd0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b01, 32'd3, 32'd4, 32'h0, 32'd12);

        @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
